// File: rtl/fifo_param_flow.sv
// Parametrised synchronous FIFO with occupancy count, programmable almost-empty/almost-full
// thresholds, hysteretic pause output and sticky, clearable overflow/underflow flags.
module fifo_param_flow #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic                  err_clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  pause,
    output logic                  overflow_err,
    output logic                  underflow_err,
    output logic                  fifo_error
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [ADDR_WIDTH:0]   count_d;

    // A pop at full frees a slot in the same edge, so a simultaneous push is accepted.
    always_comb begin
        rd_acc  = pop & ~fifo_empty;
        wr_acc  = push & (~fifo_full | rd_acc);
        count_d = count + (ADDR_WIDTH + 1)'(wr_acc) - (ADDR_WIDTH + 1)'(rd_acc);
    end

    assign fifo_error = overflow_err | underflow_err;

    // Storage has no reset; stale words are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (wr_acc && !reset) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            fifo_empty    <= 1'b1;
            fifo_full     <= 1'b0;
            almost_empty  <= 1'b1;
            almost_full   <= 1'b0;
            pause         <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
            end
            data_valid   <= rd_acc;
            count        <= count_d;
            fifo_empty   <= (count_d == '0);
            fifo_full    <= (count_d == FULL_COUNT);
            almost_empty <= (count_d <= ae_thresh);
            almost_full  <= (count_d >= af_thresh);

            // Set has priority over clear when thresholds overlap.
            if (count_d >= af_thresh) begin
                pause <= 1'b1;
            end else if (count_d <= ae_thresh) begin
                pause <= 1'b0;
            end

            if (err_clear) begin
                overflow_err  <= 1'b0;
                underflow_err <= 1'b0;
            end else begin
                if (push && fifo_full && !rd_acc) begin
                    overflow_err <= 1'b1;
                end
                if (pop && fifo_empty) begin
                    underflow_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_param_flow.sv
// Self-checking bench for fifo_param_flow: a reference queue predicts popped words into a
// scoreboard; a monitor compares them whenever data_valid is seen. Flags are checked inline.
module tb_fifo_param_flow;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [5:0] data_in = '0;
    logic [3:0] ae_thresh = 4'd2;
    logic [3:0] af_thresh = 4'd6;
    logic       err_clear = 1'b0;
    logic [5:0] data_out;
    logic       data_valid;
    logic [3:0] count;
    logic       fifo_empty;
    logic       fifo_full;
    logic       almost_empty;
    logic       almost_full;
    logic       pause;
    logic       overflow_err;
    logic       underflow_err;
    logic       fifo_error;

    int checks = 0;
    int fails = 0;
    logic [5:0] model[$];
    logic [5:0] exp_q[$];

    fifo_param_flow #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
        .ae_thresh(ae_thresh), .af_thresh(af_thresh), .err_clear(err_clear),
        .data_out(data_out), .data_valid(data_valid), .count(count),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .almost_empty(almost_empty),
        .almost_full(almost_full), .pause(pause), .overflow_err(overflow_err),
        .underflow_err(underflow_err), .fifo_error(fifo_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every data_valid pulse must match the next predicted word.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected data_valid", 1, 0);
            end else begin
                chk("data_out", int'(data_out), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // One clock of traffic; the reference queue decides acceptance independently of the DUT.
    task automatic step(input logic p, input logic q, input logic [5:0] d, input logic clr);
        logic rd;
        logic wr;
        push = p;
        pop = q;
        data_in = d;
        err_clear = clr;
        rd = q && (model.size() > 0);
        wr = p && ((model.size() < 8) || rd);
        @(posedge clk);
        if (rd) exp_q.push_back(model.pop_front());
        if (wr) model.push_back(d);
        #1;
        push = 1'b0;
        pop = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        model.delete();
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst count", int'(count), 0);
        chk("rst empty", int'(fifo_empty), 1);
        chk("rst full", int'(fifo_full), 0);
        chk("rst almost_empty", int'(almost_empty), 1);
        chk("rst almost_full", int'(almost_full), 0);
        chk("rst pause", int'(pause), 0);
        chk("rst fifo_error", int'(fifo_error), 0);
        chk("rst data_valid", int'(data_valid), 0);

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 6'(i), 1'b0);
            chk("fill count", int'(count), i);
            chk("fill empty", int'(fifo_empty), 0);
            chk("fill full", int'(fifo_full), (i == 8) ? 1 : 0);
            chk("fill almost_full", int'(almost_full), (i >= 6) ? 1 : 0);
            chk("fill pause", int'(pause), (i >= 6) ? 1 : 0);
        end

        // Drain; pause holds down to 3 and clears at 2
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 6'h00, 1'b0);
            chk("drain count", int'(count), 8 - i);
            chk("drain valid", int'(data_valid), 1);
            chk("drain data", int'(data_out), i);
            chk("drain pause", int'(pause), (8 - i >= 3) ? 1 : 0);
            chk("drain almost_empty", int'(almost_empty), (8 - i <= 2) ? 1 : 0);
        end
        chk("drained empty", int'(fifo_empty), 1);
        step(1'b0, 1'b0, 6'h00, 1'b0);
        chk("idle valid", int'(data_valid), 0);
        chk("idle data_out hold", int'(data_out), 8);

        // Push+pop at full: read-first, count stays 8, no error
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6'h11 + 6'(i), 1'b0);
        step(1'b1, 1'b1, 6'h2A, 1'b0);
        chk("fullpp data", int'(data_out), 'h11);
        chk("fullpp count", int'(count), 8);
        chk("fullpp error", int'(fifo_error), 0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 6'h00, 1'b0);
        step(1'b0, 1'b1, 6'h00, 1'b0);
        chk("fullpp last word", int'(data_out), 'h2A);

        // Underflow: sticky, then cleared
        step(1'b0, 1'b1, 6'h00, 1'b0);
        chk("uf flag", int'(underflow_err), 1);
        chk("uf fifo_error", int'(fifo_error), 1);
        chk("uf count", int'(count), 0);
        chk("uf valid", int'(data_valid), 0);
        repeat (3) step(1'b0, 1'b0, 6'h00, 1'b0);
        chk("uf sticky", int'(underflow_err), 1);
        step(1'b0, 1'b0, 6'h00, 1'b1);
        chk("uf cleared", int'(underflow_err), 0);

        // Push+pop while empty: word written, nothing read, underflow set
        step(1'b1, 1'b1, 6'h3C, 1'b0);
        chk("empty pp count", int'(count), 1);
        chk("empty pp uf", int'(underflow_err), 1);
        step(1'b0, 1'b1, 6'h00, 1'b1);
        chk("empty pp cleared", int'(underflow_err), 0);

        // Overflow at full; err_clear drops a same-cycle error
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 6'h20 + 6'(i), 1'b0);
        step(1'b1, 1'b0, 6'h3F, 1'b0);
        chk("of flag", int'(overflow_err), 1);
        chk("of count", int'(count), 8);
        step(1'b1, 1'b0, 6'h3F, 1'b1);
        chk("of clear wins", int'(overflow_err), 0);

        // Threshold changes take effect without traffic
        af_thresh = 4'd9;
        step(1'b0, 1'b0, 6'h00, 1'b0);
        chk("af>depth almost_full", int'(almost_full), 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 6'h00, 1'b0);
        ae_thresh = 4'd8;
        af_thresh = 4'd0;
        step(1'b0, 1'b0, 6'h00, 1'b0);
        chk("af=0 almost_full", int'(almost_full), 1);
        chk("ae>=depth almost_empty", int'(almost_empty), 1);
        chk("overlap pause set wins", int'(pause), 1);
        ae_thresh = 4'd2;
        af_thresh = 4'd6;
        step(1'b0, 1'b0, 6'h00, 1'b0);
        chk("restored pause clear", int'(pause), 0);

        // Pointer wrap: 11 pushes, 3 interleaved pops
        for (int i = 0; i < 11; i++) begin
            step(1'b1, (i == 2 || i == 5 || i == 8), 6'h30 + 6'(i), 1'b0);
        end
        chk("wrap count", int'(count), 8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 6'h00, 1'b0);
        step(1'b1, 1'b0, 6'h15, 1'b0);
        step(1'b1, 1'b0, 6'h16, 1'b0);
        step(1'b1, 1'b0, 6'h17, 1'b0);
        step(1'b1, 1'b0, 6'h18, 1'b0);
        chk("pre-reset overflow", int'(overflow_err), 1);

        // Reset mid-stream with push and pop asserted
        push = 1'b1;
        pop = 1'b1;
        data_in = 6'h2B;
        do_reset();
        chk("midrst count", int'(count), 0);
        chk("midrst empty", int'(fifo_empty), 1);
        chk("midrst valid", int'(data_valid), 0);
        chk("midrst error", int'(fifo_error), 0);
        chk("midrst pause", int'(pause), 0);

        // FIFO still orders correctly after reset
        step(1'b1, 1'b0, 6'h05, 1'b0);
        step(1'b1, 1'b1, 6'h06, 1'b0);
        step(1'b0, 1'b1, 6'h00, 1'b0);
        chk("post-rst data", int'(data_out), 'h06);
        step(1'b0, 1'b0, 6'h00, 1'b0);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fifo_param_flow.md
Name: fifo_param_flow

Overview:
- Parametrised successor of the 6-bit FIFO: configurable data width and depth.
- Runtime-programmable almost-empty/almost-full thresholds, hysteretic pause output, occupancy count.
- Legal simultaneous push/pop in every state, including full.
- Sticky, clearable overflow/underflow error flags.
- Sits between a packet producer and consumer; pause throttles the upstream producer.

Parameters:
- DATA_WIDTH, 6, width of data_in/data_out.
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries (default 8).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  write request, data_in sampled same edge.
- pop  in  1  read request.
- data_in  in  DATA_WIDTH  write data.
- ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold (count <= ae_thresh).
- af_thresh  in  ADDR_WIDTH+1  almost-full threshold (count >= af_thresh).
- err_clear  in  1  clears sticky error flags.
- data_out  out  DATA_WIDTH  read data, registered.
- data_valid  out  1  one-cycle pulse, data_out holds popped word.
- count  out  ADDR_WIDTH+1  current occupancy 0..DEPTH.
- fifo_empty  out  1  count == 0.
- fifo_full  out  1  count == DEPTH.
- almost_empty  out  1  count <= ae_thresh.
- almost_full  out  1  count >= af_thresh.
- pause  out  1  hysteretic back-pressure to producer.
- overflow_err  out  1  sticky: push rejected while full.
- underflow_err  out  1  sticky: pop rejected while empty.
- fifo_error  out  1  overflow_err | underflow_err.

Behaviour:
- Reset (sync, high; dominates every other input, including mid-operation):
  - wr_ptr, rd_ptr, count, data_out, data_valid, fifo_full, almost_full, pause, errors all 0.
  - fifo_empty = 1, almost_empty = 1.
  - Memory contents are not cleared; they are unreachable until rewritten.
- Accept rules, evaluated on current registered state:
  - rd_acc = pop & ~fifo_empty.
  - wr_acc = push & (~fifo_full | rd_acc).
- Accepted write:
  - mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH (natural wrap of ADDR_WIDTH bits).
- Accepted read:
  - data_out <= mem[rd_ptr] at the same edge, so latency is 1 cycle from pop to data_out.
  - data_valid = 1 for that cycle; rd_ptr increments modulo DEPTH.
  - Rejected or absent pop: data_valid = 0 and data_out holds its last value.
- Push and pop at full:
  - wr_ptr == rd_ptr, so read-first semantics apply: data_out gets the old word and the new word is stored.
  - count stays at DEPTH.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. It never leaves 0..DEPTH.
- Status flags are registered from the next count value and valid in the same cycle as count.
  - Threshold inputs are sampled every edge; a change is reflected in the flags one edge later even with no traffic.
  - ae_thresh >= DEPTH forces almost_empty = 1; af_thresh = 0 forces almost_full = 1.
  - af_thresh > DEPTH means almost_full never asserts.
- pause (hysteresis):
  - Set when next count >= af_thresh.
  - Cleared when next count <= ae_thresh.
  - Otherwise holds its value.
  - If both conditions are true (misprogrammed thresholds), set wins.
- Errors:
  - overflow_err set on push & fifo_full & ~rd_acc.
  - underflow_err set on pop & fifo_empty. Push+pop while empty writes the word, does not read, and sets underflow_err.
  - Both are sticky until reset or err_clear. err_clear takes priority, so a same-cycle error event is dropped.
  - A rejected operation never changes pointers, count or memory.

Test Plan:
- Reset, then push 0x01..0x08 on consecutive cycles → count 1..8; fifo_full=1 after the 8th edge; almost_full=1 from count>=6 (af_thresh=6); fifo_empty=0 after the 1st edge.
- Full FIFO, pop 8 times → data_out 0x01..0x08 one cycle after each pop with data_valid pulsing; fifo_empty=1 and count=0 after the 8th.
- ae_thresh=2, af_thresh=6, fill to 6 → pause=1; drain to 3 → pause still 1; drain to 2 → pause=0.
- Full FIFO, push 0x2A with pop same cycle → data_out=0x01, count stays 8, no error; 0x2A is read out 8 pops later.
- Empty FIFO, pop → underflow_err=1, fifo_error=1, count=0; 3 idle cycles → still 1; err_clear → 0 next edge. Full FIFO, push → overflow_err=1, count=8.
- Push 11 and pop 3 interleaved so pointers wrap past 7 → FIFO order preserved; reset asserted mid-stream → next edge count=0, fifo_empty=1, data_valid=0, errors=0.
